mul_seq: RTL and testbench
==========================

Name: mul_seq

Overview:
- Multi-cycle 8-bit unsigned multiplier controller. It has no adder of its own.
- It computes op_a*op_b mod 256 by sequencing the shared ula through AND/ADD/SLL/SRL micro-ops (shift-and-add).
- It shares the ula with the CPU datapath through a req/gnt handshake and sits beside the datapath as a coprocessor.
- The CPU starts it with a one-cycle start pulse and collects the product when done pulses.

Parameters:
WIDTH, 8, data width. Must equal the ula width; only 8 is supported.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request a multiply; sampled only in IDLE
op_a  in  8  multiplicand, sampled with start
op_b  in  8  multiplier, sampled with start
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse; product valid
product  out  8  result, held until the next accepted start
alu_req  out  1  ula wanted this cycle
alu_gnt  in  1  ula inputs owned by this block this cycle
alu_op  out  4  ula opcode; 4'b0000 when not requesting
alu_ra  out  8  ula operand A; 0 when not requesting
alu_rb  out  8  ula operand B; 0 when not requesting
alu_s  in  8  ula result (combinational)
alu_zero  in  1  ula zero flag, equal to (alu_s==0)

Behaviour:
- ula contract. All ops are combinational and 8-bit wrapping:
  - AND 4'b0001: s = ra & rb
  - ADD 4'b0100: s = ra + rb
  - SLL 4'b0110: s = ra << rb
  - SRL 4'b0111: s = ra >> rb
- Internal registers: acc, mcand, mplier (8 bits each); state.
- Reset (async, rst_n=0): state=IDLE; acc, mcand, mplier, product = 0; busy=0; done=0; alu_req=0. Reset mid-operation abandons the operation with no done pulse.
- IDLE:
  - If start=1: acc<=0, mcand<=op_a, mplier<=op_b, product<=0, next state TEST.
  - If start=0: stay in IDLE.
- TEST: drive AND, ra=mplier, rb=1. On gnt: next state SHL if alu_zero=1, else ADD.
- ADD: drive ADD, ra=acc, rb=mcand. On gnt: acc<=alu_s, next state SHL.
- SHL: drive SLL, ra=mcand, rb=1. On gnt: mcand<=alu_s, next state SHR.
- SHR: drive SRL, ra=mplier, rb=1. On gnt: mplier<=alu_s; next state DONE if alu_zero=1, else TEST.
- DONE: product<=acc at entry, i.e. in the same edge that leaves SHR. done=1 for this one cycle, alu_req=0, next state IDLE.
- alu_req=1 combinationally in TEST/ADD/SHL/SHR.
- Stall: if alu_gnt=0, state and registers hold and the same request repeats next cycle. alu_s/alu_zero are ignored in no-grant cycles. gnt may drop at any cycle.
- No-stall latency, counted from the start edge to the edge entering DONE:
  - Per multiplier bit: 4 cycles if the bit is 1, 3 cycles if it is 0.
  - Iterations = index of the highest set bit of op_b + 1. op_b=0 takes 1 iteration.
  - done is high in the cycle after the last SHR.
- Boundary cases:
  - start while busy: ignored.
  - start in the DONE cycle: ignored; it is accepted only in IDLE.
  - start held high: a new operation begins every time IDLE is reached.
  - The product discards bits above bit 7; there is no overflow flag.

Decomposition:
- Shared package ula_pkg holds:
  - ula opcode localparams ULA_NOT, ULA_AND, ULA_OR, ULA_XOR, ULA_ADD, ULA_SUB, ULA_SLL, ULA_SRL, ULA_INC, ULA_SLL4;
  - mul_seq state encoding (IDLE, TEST, ADD, SHL, SHR, DONE).
- No sub-module: one FSM plus the datapath registers. The bench instantiates the real ula and ties alu_* to it.

Test Plan:
1. gnt tied 1, op_a=3, op_b=5 -> done pulses 11 cycles after the start edge, product=15, busy high for those 11 cycles.
2. gnt=1, op_a=8'hFF, op_b=8'hFF -> product=8'h01, done 32 cycles after start; op_a=8'h10, op_b=8'h10 -> product=8'h00 (wrap), 16 cycles.
3. gnt=1, op_b=0, op_a=8'h7F -> product=0 after 3 cycles; then op_a=0, op_b=8'h80 -> product=0 after 25 cycles.
4. op_a=3, op_b=5, gnt toggling 1,0,1,0,... -> product=15 after 21 cycles; alu_op/ra/rb stable across each no-grant cycle; registers unchanged in stalled cycles.
5. start pulses while busy and in the DONE cycle -> ignored; the first result is unchanged, and product holds its value until the next start is accepted in IDLE.
6. rst_n low mid-multiply (state ADD) -> same cycle: busy=0, product=0, alu_req=0; after release the block is in IDLE and a new op_a=6, op_b=7 gives product=42.

Source files
------------

// File: rtl/ula_pkg.sv
// Shared definitions for the ula and the units that borrow it.
// Holds the ula opcodes and the mul_seq controller state encoding.
package ula_pkg;

  localparam int ULA_WIDTH = 8;

  localparam logic [3:0] ULA_NOT  = 4'b0000;
  localparam logic [3:0] ULA_AND  = 4'b0001;
  localparam logic [3:0] ULA_OR   = 4'b0010;
  localparam logic [3:0] ULA_XOR  = 4'b0011;
  localparam logic [3:0] ULA_ADD  = 4'b0100;
  localparam logic [3:0] ULA_SUB  = 4'b0101;
  localparam logic [3:0] ULA_SLL  = 4'b0110;
  localparam logic [3:0] ULA_SRL  = 4'b0111;
  localparam logic [3:0] ULA_INC  = 4'b1000;
  localparam logic [3:0] ULA_SLL4 = 4'b1001;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_TEST = 3'd1,
    S_ADD  = 3'd2,
    S_SHL  = 3'd3,
    S_SHR  = 3'd4,
    S_DONE = 3'd5
  } mul_state_e;

endpackage

// File: rtl/ula.sv
// Combinational 8-bit ula shared between the CPU datapath and coprocessors.
// All results wrap to the data width; zero mirrors (s == 0).
module ula
  import ula_pkg::*;
(
  input  logic [3:0]           op,
  input  logic [ULA_WIDTH-1:0] ra,
  input  logic [ULA_WIDTH-1:0] rb,
  output logic [ULA_WIDTH-1:0] s,
  output logic                 zero
);

  always_comb begin
    s = '0;
    case (op)
      ULA_NOT:  s = ~ra;
      ULA_AND:  s = ra & rb;
      ULA_OR:   s = ra | rb;
      ULA_XOR:  s = ra ^ rb;
      ULA_ADD:  s = ra + rb;
      ULA_SUB:  s = ra - rb;
      ULA_SLL:  s = ra << rb;
      ULA_SRL:  s = ra >> rb;
      ULA_INC:  s = ra + ULA_WIDTH'(1);
      ULA_SLL4: s = ra << 4;
      default:  s = '0;
    endcase
  end

  assign zero = (s == '0);

endmodule

// File: rtl/mul_seq.sv
// Shift-and-add 8-bit multiplier controller that borrows the shared ula
// through a req/gnt handshake; it owns no adder of its own.
module mul_seq
  import ula_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic             alu_req,
  input  logic             alu_gnt,
  output logic [3:0]       alu_op,
  output logic [WIDTH-1:0] alu_ra,
  output logic [WIDTH-1:0] alu_rb,
  input  logic [WIDTH-1:0] alu_s,
  input  logic             alu_zero
);

  mul_state_e       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] product_q, product_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      product_q <= product_d;
    end
  end

  // Every ula-using state only advances on a grant; otherwise it re-issues
  // the identical request and ignores alu_s/alu_zero.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    product_d = product_q;
    alu_req   = 1'b0;
    alu_op    = 4'b0000;
    alu_ra    = '0;
    alu_rb    = '0;
    done      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d     = '0;
          mcand_d   = op_a;
          mplier_d  = op_b;
          product_d = '0;
          state_d   = S_TEST;
        end
      end
      S_TEST: begin
        alu_req = 1'b1;
        alu_op  = ULA_AND;
        alu_ra  = mplier_q;
        alu_rb  = WIDTH'(1);
        if (alu_gnt) begin
          state_d = alu_zero ? S_SHL : S_ADD;
        end
      end
      S_ADD: begin
        alu_req = 1'b1;
        alu_op  = ULA_ADD;
        alu_ra  = acc_q;
        alu_rb  = mcand_q;
        if (alu_gnt) begin
          acc_d   = alu_s;
          state_d = S_SHL;
        end
      end
      S_SHL: begin
        alu_req = 1'b1;
        alu_op  = ULA_SLL;
        alu_ra  = mcand_q;
        alu_rb  = WIDTH'(1);
        if (alu_gnt) begin
          mcand_d = alu_s;
          state_d = S_SHR;
        end
      end
      S_SHR: begin
        alu_req = 1'b1;
        alu_op  = ULA_SRL;
        alu_ra  = mplier_q;
        alu_rb  = WIDTH'(1);
        if (alu_gnt) begin
          mplier_d = alu_s;
          // Multiplier exhausted: latch the product on the way into DONE.
          if (alu_zero) begin
            product_d = acc_q;
            state_d   = S_DONE;
          end else begin
            state_d = S_TEST;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy    = (state_q != S_IDLE);
  assign product = product_q;

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq wired to the real ula, with a
// transaction-level reference model checked on every falling edge.
module tb_mul_seq;
  import ula_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] op_a, op_b;
  logic       busy, done;
  logic [7:0] product;
  logic       alu_req, alu_gnt, alu_zero;
  logic [3:0] alu_op;
  logic [7:0] alu_ra, alu_rb, alu_s;

  int pass_cnt = 0;
  int total_cnt = 0;

  mul_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .product(product),
    .alu_req(alu_req), .alu_gnt(alu_gnt), .alu_op(alu_op),
    .alu_ra(alu_ra), .alu_rb(alu_rb), .alu_s(alu_s), .alu_zero(alu_zero)
  );

  ula u_ula (.op(alu_op), .ra(alu_ra), .rb(alu_rb), .s(alu_s), .zero(alu_zero));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    else
      pass_cnt++;
  endtask

  // Granted ula cycles needed for a multiplier value: 4 per set bit,
  // 3 per clear bit, up to and including the highest set bit (min one).
  function automatic int grants_needed(input logic [7:0] b);
    int hi = 0;
    int t = 0;
    for (int i = 0; i < 8; i++) if (b[i]) hi = i;
    for (int i = 0; i <= hi; i++) t += b[i] ? 4 : 3;
    return t;
  endfunction

  // Reference model: idle / working (counting granted cycles) / done.
  logic       m_busy, m_done;
  int         m_left;
  logic [7:0] m_prod, m_pend;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_left <= 0;
      m_prod <= 8'h00;
      m_pend <= 8'h00;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy <= 1'b1;
        m_left <= grants_needed(op_b);
        m_prod <= 8'h00;
        m_pend <= 8'(op_a * op_b);
      end
    end else if (alu_gnt) begin
      if (m_left == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_prod <= m_pend;
      end
      m_left <= m_left - 1;
    end
  end

  logic       prev_req, prev_gnt;
  logic [3:0] prev_op;
  logic [7:0] prev_ra, prev_rb;

  always @(negedge clk) begin
    check("busy", {31'd0, busy}, {31'd0, m_busy | m_done});
    check("done", {31'd0, done}, {31'd0, m_done});
    check("product", {24'd0, product}, {24'd0, m_prod});
    check("alu_req", {31'd0, alu_req}, {31'd0, m_busy});
    if (!alu_req)
      check("idle_operands", {12'd0, alu_op, alu_ra, alu_rb}, 32'd0);
    if (rst_n && prev_req && !prev_gnt && alu_req)
      check("stall_hold", {12'd0, alu_op, alu_ra, alu_rb},
            {12'd0, prev_op, prev_ra, prev_rb});
    prev_req = alu_req && rst_n;
    prev_gnt = alu_gnt;
    prev_op  = alu_op;
    prev_ra  = alu_ra;
    prev_rb  = alu_rb;
  end

  // Runs one multiply; gnt optionally toggles 1,0,1,... from the first
  // request cycle, and inject adds a start while busy and in the DONE cycle.
  task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                        input bit toggle, input bit inject,
                        input logic [7:0] exp_prod, input int exp_cycles);
    int n;
    int done_at;
    bit seen;
    @(posedge clk); #1;
    start = 1'b1; op_a = a; op_b = b; alu_gnt = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0; seen = 1'b0; done_at = -1;
    while (!seen && n < 200) begin
      alu_gnt = toggle ? (n % 2 == 0) : 1'b1;
      if (inject && n == 3) begin
        start = 1'b1; op_a = 8'h09; op_b = 8'h09;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        done_at = n;
        if (inject) begin
          start = 1'b1; op_a = 8'h02; op_b = 8'h02;
        end
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    alu_gnt = 1'b1;
    check({name, "_done_seen"}, {31'd0, seen}, 32'd1);
    check({name, "_latency"}, done_at, exp_cycles);
    check({name, "_product"}, {24'd0, product}, {24'd0, exp_prod});
    $display("op %s: a=%02h b=%02h product=%02h latency=%0d", name, a, b, product, done_at);
    if (inject) begin
      repeat (3) @(posedge clk);
      #1;
      check({name, "_held"}, {24'd0, product}, {24'd0, exp_prod});
      check({name, "_idle"}, {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op_a = 8'h00; op_b = 8'h00; alu_gnt = 1'b1;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_product", {24'd0, product}, 32'd0);
    check("rst_req", {31'd0, alu_req}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    run_op("a3b5", 8'h03, 8'h05, 1'b0, 1'b0, 8'h0F, 11);
    run_op("ffxff", 8'hFF, 8'hFF, 1'b0, 1'b0, 8'h01, 32);
    run_op("wrap", 8'h10, 8'h10, 1'b0, 1'b0, 8'h00, 16);
    run_op("b0", 8'h7F, 8'h00, 1'b0, 1'b0, 8'h00, 3);
    run_op("a0b80", 8'h00, 8'h80, 1'b0, 1'b0, 8'h00, 25);
    run_op("stall", 8'h03, 8'h05, 1'b1, 1'b0, 8'h0F, 21);
    run_op("inject", 8'h0B, 8'h0D, 1'b0, 1'b1, 8'h8F, 15);

    // Abort in ADD: TEST takes one edge after the start edge.
    @(posedge clk); #1;
    start = 1'b1; op_a = 8'h03; op_b = 8'h05;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("abort_in_add", {28'd0, alu_op}, {28'd0, ULA_ADD});
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_product", {24'd0, product}, 32'd0);
    check("abort_req", {31'd0, alu_req}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    run_op("a6b7", 8'h06, 8'h07, 1'b0, 1'b0, 8'h2A, 12);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
